// File: rtl/wb2ahb_pkg.sv
// wb2ahb_pkg: shared AHB encodings and bridge FSM state type for the
// Wishbone-slave to AHB-master bridge.
package wb2ahb_pkg;

  // AHB transfer types (only IDLE and NONSEQ are ever issued)
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // AHB slave response codes
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  // AHB transfer sizes
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Only single transfers are issued
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_RESP1 = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/wb2ahb_sel_decode.sv
// wb2ahb_sel_decode: combinational decode of Wishbone byte-lane selects
// into an AHB transfer size and the low two address bits (little-endian).
// Ports:
//   sel    in  4  Wishbone byte-lane selects
//   legal  out 1  pattern maps onto a naturally aligned byte/half/word
//   hsize  out 3  AHB size code for the pattern
//   offset out 2  byte offset of the lowest selected lane
module wb2ahb_sel_decode
  import wb2ahb_pkg::*;
(
  input  logic [3:0] sel,
  output logic       legal,
  output logic [2:0] hsize,
  output logic [1:0] offset
);

  // Map each legal lane pattern onto size/offset; everything else is illegal
  always_comb begin
    legal  = 1'b0;
    hsize  = HSIZE_WORD;
    offset = 2'b00;
    case (sel)
      4'b1111: begin legal = 1'b1; hsize = HSIZE_WORD; offset = 2'b00; end
      4'b0011: begin legal = 1'b1; hsize = HSIZE_HALF; offset = 2'b00; end
      4'b1100: begin legal = 1'b1; hsize = HSIZE_HALF; offset = 2'b10; end
      4'b0001: begin legal = 1'b1; hsize = HSIZE_BYTE; offset = 2'b00; end
      4'b0010: begin legal = 1'b1; hsize = HSIZE_BYTE; offset = 2'b01; end
      4'b0100: begin legal = 1'b1; hsize = HSIZE_BYTE; offset = 2'b10; end
      4'b1000: begin legal = 1'b1; hsize = HSIZE_BYTE; offset = 2'b11; end
      default: begin legal = 1'b0; hsize = HSIZE_WORD; offset = 2'b00; end
    endcase
  end

endmodule

// File: rtl/wb2ahb.sv
// wb2ahb: Wishbone classic-cycle slave to AHB master bridge. Each Wishbone
// read/write is replayed as one AHB SINGLE/NONSEQ transfer after arbitration.
// RETRY/SPLIT responses re-arbitrate and re-issue up to RETRY_MAX times.
// Ports:
//   hclk, hresetn              clock, synchronous active-low reset
//   adr_i/dat_i/sel_i/we_i     Wishbone word address, write data, lanes, dir
//   cyc_i/stb_i                Wishbone cycle and strobe
//   dat_o/ack_o/err_o          Wishbone read data and one-cycle completions
//   hbusreq/hlock/hgrant       AHB arbitration (hlock tied low)
//   haddr/htrans/hwrite/hsize/hburst/hwdata   AHB master address/data
//   hrdata/hready/hresp        AHB slave response
module wb2ahb
  import wb2ahb_pkg::*;
#(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int RETRY_MAX = 4
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [AWIDTH-3:0] adr_i,
  input  logic [DWIDTH-1:0] dat_i,
  input  logic [3:0]        sel_i,
  input  logic              we_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic [DWIDTH-1:0] dat_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              hbusreq,
  output logic              hlock,
  input  logic              hgrant,
  output logic [AWIDTH-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DWIDTH-1:0] hwdata,
  input  logic [DWIDTH-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  // Counter must be able to hold RETRY_MAX+1 so the overflow is visible
  localparam int              CNT_W   = $clog2(RETRY_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RETRY_MAX);

  state_e              state_r;
  logic [AWIDTH-3:0]   adr_r;
  logic [DWIDTH-1:0]   wdat_r;
  logic                we_r;
  logic [2:0]          size_r;
  logic [1:0]          off_r;
  logic                err_flag_r;   // RESP1 cause: 1 = ERROR, 0 = RETRY/SPLIT
  logic                started_r;    // an AHB address phase has been issued
  logic [CNT_W-1:0]    retry_cnt_r;

  logic                sel_legal_s;
  logic [2:0]          sel_size_s;
  logic [1:0]          sel_off_s;
  logic [CNT_W-1:0]    retry_nxt_s;

  wb2ahb_sel_decode u_sel_decode (
    .sel    (sel_i),
    .legal  (sel_legal_s),
    .hsize  (sel_size_s),
    .offset (sel_off_s)
  );

  assign retry_nxt_s = retry_cnt_r + CNT_ONE;
  assign hlock       = 1'b0;
  assign hburst      = HBURST_SINGLE;

  // Bridge FSM with all AHB/Wishbone outputs registered on the transitions
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_r     <= ST_IDLE;
      adr_r       <= '0;
      wdat_r      <= '0;
      we_r        <= 1'b0;
      size_r      <= HSIZE_WORD;
      off_r       <= 2'b00;
      err_flag_r  <= 1'b0;
      started_r   <= 1'b0;
      retry_cnt_r <= '0;
      dat_o       <= '0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      hbusreq     <= 1'b0;
      haddr       <= '0;
      htrans      <= HTRANS_IDLE;
      hwrite      <= 1'b0;
      hsize       <= HSIZE_WORD;
      hwdata      <= '0;
    end else begin
      // Completions are single-cycle pulses
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cyc_i && stb_i) begin
            adr_r  <= adr_i;
            wdat_r <= dat_i;
            we_r   <= we_i;
            size_r <= sel_size_s;
            off_r  <= sel_off_s;
            if (sel_legal_s) begin
              state_r <= ST_REQ;
              hbusreq <= 1'b1;
            end else begin
              // Unencodable lane pattern: reject without touching AHB
              state_r <= ST_DONE;
              err_o   <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // Abort is only allowed before the first address phase; a
          // re-request after RETRY/SPLIT must run to completion.
          if (!cyc_i && !started_r) begin
            state_r <= ST_IDLE;
            hbusreq <= 1'b0;
          end else if (hgrant && hready) begin
            state_r   <= ST_ADDR;
            started_r <= 1'b1;
            haddr     <= {adr_r, off_r};
            hwrite    <= we_r;
            hsize     <= size_r;
            htrans    <= HTRANS_NONSEQ;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_ADDR: begin
          // Address/control hold until the previous data phase frees the bus
          if (hready) begin
            state_r <= ST_DATA;
            htrans  <= HTRANS_IDLE;
            hbusreq <= 1'b0;
            hwdata  <= wdat_r;
          end else begin
            state_r <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (hready) begin
            state_r <= ST_DONE;
            if (hresp == HRESP_OKAY) begin
              if (!we_r) begin
                dat_o <= hrdata;
              end else begin
                dat_o <= dat_o;
              end
              ack_o <= cyc_i;
            end else begin
              // Single-cycle non-OKAY response is a slave protocol error
              err_o <= cyc_i;
            end
          end else if (hresp == HRESP_ERROR) begin
            state_r    <= ST_RESP1;
            err_flag_r <= 1'b1;
          end else if ((hresp == HRESP_RETRY) || (hresp == HRESP_SPLIT)) begin
            state_r    <= ST_RESP1;
            err_flag_r <= 1'b0;
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_RESP1: begin
          if (hready) begin
            if (err_flag_r) begin
              state_r <= ST_DONE;
              err_o   <= cyc_i;
            end else begin
              retry_cnt_r <= retry_nxt_s;
              if (retry_nxt_s > CNT_MAX) begin
                state_r <= ST_DONE;
                err_o   <= cyc_i;
              end else begin
                state_r <= ST_REQ;
                hbusreq <= 1'b1;
              end
            end
          end else begin
            state_r <= ST_RESP1;
          end
        end
        ST_DONE: begin
          // ack/err was gated with cyc_i as the bridge entered DONE
          state_r     <= ST_IDLE;
          retry_cnt_r <= '0;
          started_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          hbusreq <= 1'b0;
          htrans  <= HTRANS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb2ahb.sv
// tb_wb2ahb: self-checking bench for wb2ahb. A driver issues Wishbone
// transactions and pushes the expected completion into a scoreboard queue;
// a monitor pops and compares whenever ack_o/err_o appears. A behavioural
// AHB slave/arbiter answers with configurable grant delay, wait states,
// RETRY/SPLIT counts and ERROR responses, and checks each NONSEQ issue.
module tb_wb2ahb;
  import wb2ahb_pkg::*;

  localparam int RMAX = 4;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [29:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        we_i, cyc_i, stb_i;
  logic [31:0] dat_o;
  logic        ack_o, err_o, hbusreq, hlock, hgrant;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata, hrdata;
  logic        hready;
  logic [1:0]  hresp;

  wb2ahb #(.AWIDTH(32), .DWIDTH(32), .RETRY_MAX(RMAX)) dut (
    .hclk(hclk), .hresetn(hresetn), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .dat_o(dat_o), .ack_o(ack_o),
    .err_o(err_o), .hbusreq(hbusreq), .hlock(hlock), .hgrant(hgrant),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic        is_err;
    logic        chk_data;
    logic [31:0] data;
  } resp_t;

  resp_t sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Slave configuration and expected transfer, written by the driver
  int          cfg_waits = 0, cfg_gdelay = 0, rt_left = 0, issues = 0;
  bit          cfg_err = 1'b0, breq_seen = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
  logic [2:0]  exp_size = 3'b010;
  logic        exp_write = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {ack_o, err_o, hbusreq, hlock, htrans, hwrite, hsize, hburst},
          {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010, 3'b000});
    check({tag, "_haddr"}, haddr, 32'h0);
    check({tag, "_hwdata"}, hwdata, 32'h0);
    check({tag, "_dat_o"}, dat_o, 32'h0);
  endtask

  // Behavioural AHB arbiter + slave; decisions made at negedge for next posedge
  initial begin : ahb_slave
    int   phase;        // 0: idle/address, 1: data phase, 2: second response cycle
    int   waits_left;
    int   gcnt;
    bit   first_dp;
    phase = 0; waits_left = 0; gcnt = 0; first_dp = 1'b0;
    hready = 1'b1; hresp = HRESP_OKAY; hrdata = 32'h0; hgrant = 1'b0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        phase = 0; gcnt = 0;
        hready = 1'b1; hresp = HRESP_OKAY; hgrant = 1'b0;
      end else begin
        if (hbusreq) begin
          breq_seen = 1'b1;
          hgrant = (gcnt >= cfg_gdelay);
          gcnt++;
        end else begin
          hgrant = 1'b0;
          gcnt = 0;
        end
        case (phase)
          0: begin
            hready = 1'b1; hresp = HRESP_OKAY; hrdata = $urandom;
            if (htrans == HTRANS_NONSEQ) begin
              issues++;
              check("haddr", haddr, exp_addr);
              check("hsize", hsize, exp_size);
              check("hwrite", hwrite, exp_write);
              check("hburst_hlock", {hburst, hlock}, 4'b0000);
              check("hbusreq_in_addr", hbusreq, 1'b1);
              waits_left = cfg_waits; first_dp = 1'b1; phase = 1;
            end
          end
          1: begin
            if (first_dp) begin
              check("hwdata", hwdata, exp_wdata);
              check("htrans_data", htrans, HTRANS_IDLE);
              first_dp = 1'b0;
            end
            hrdata = $urandom;
            if (waits_left > 0) begin
              hready = 1'b0; hresp = HRESP_OKAY; waits_left--;
            end else if (rt_left > 0) begin
              hready = 1'b0; hresp = ($urandom_range(0, 1) == 0) ? HRESP_RETRY : HRESP_SPLIT;
              rt_left--; phase = 2;
            end else if (cfg_err) begin
              hready = 1'b0; hresp = HRESP_ERROR; phase = 2;
            end else begin
              hready = 1'b1; hresp = HRESP_OKAY; hrdata = cfg_rdata; phase = 0;
            end
          end
          2: begin
            hready = 1'b1; phase = 0;
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // Scoreboard monitor: every completion must match the oldest expectation
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge hclk);
      if (hresetn && (ack_o || err_o)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", {ack_o, err_o}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          check("resp_kind", {ack_o, err_o}, e.is_err ? 2'b01 : 2'b10);
          if (e.chk_data) check("dat_o", dat_o, e.data);
        end
      end
    end
  end

  // One Wishbone transaction; expectations derived from lane/response rules
  task automatic do_txn(input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, input int waits, input int retries, input bit errr,
                        input int g, input logic [31:0] rdata, input string tag);
    int    n, low, lat_exp, cyc_cnt, exp_issues;
    bit    legal, exp_is_err;
    resp_t e;
    logic [3:0] mask;
    n = $countones(sel);
    low = 0;
    for (int i = 3; i >= 0; i--) if (sel[i]) low = i;
    mask = 4'(((1 << n) - 1) << low);
    // Legal = naturally aligned run of 1, 2 or 4 lanes
    legal = ((n == 1) || (n == 2) || (n == 4)) && (sel == mask) && ((low % n) == 0);
    exp_addr  = {adr, 2'(low)};
    exp_size  = (n == 4) ? 3'b010 : ((n == 2) ? 3'b001 : 3'b000);
    exp_write = we;
    exp_wdata = dat;
    cfg_waits = waits; rt_left = retries; cfg_err = errr; cfg_gdelay = g; cfg_rdata = rdata;
    issues = 0; breq_seen = 1'b0;
    exp_is_err = !legal || errr || (retries > RMAX);
    exp_issues = !legal ? 0 : ((retries > RMAX) ? RMAX + 1 : retries + 1);
    if (!legal) lat_exp = 1;
    else if (retries > 0) lat_exp = -1;
    else if (errr) lat_exp = 5 + g + waits;
    else lat_exp = 4 + g + waits;
    e.is_err = exp_is_err; e.chk_data = !exp_is_err && !we; e.data = rdata;
    sb_q.push_back(e);
    adr_i = adr; dat_i = dat; sel_i = sel; we_i = we; cyc_i = 1'b1; stb_i = 1'b1;
    cyc_cnt = 0;
    do begin
      @(negedge hclk);
      cyc_cnt++;
    end while (!(ack_o || err_o) && (cyc_cnt < 300));
    if (!(ack_o || err_o)) begin
      check({tag, "_timeout"}, 1'b0, 1'b1);
      sb_q.delete();
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    if (lat_exp >= 0) check({tag, "_latency"}, cyc_cnt, lat_exp);
    check({tag, "_issues"}, issues, exp_issues);
    if (!legal) check({tag, "_no_busreq"}, breq_seen, 1'b0);
    @(negedge hclk);
    check({tag, "_sb_drained"}, sb_q.size(), 0);
    check({tag, "_bus_idle"}, {hbusreq, htrans}, 3'b000);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    int cyc_cnt;
    hresetn = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0;
    repeat (3) @(negedge hclk);
    check_reset_vals("reset");
    hresetn = 1'b1;
    @(negedge hclk);

    do_txn(30'h400, 32'hDEADBEEF, 4'b1111, 1'b1, 0, 0, 1'b0, 0, 32'h0, "wr_word");
    do_txn(30'h10, 32'h12345678, 4'b0100, 1'b0, 2, 0, 1'b0, 0, 32'h00AB0000, "rd_byte");
    do_txn(30'h2A5, 32'hCAFEF00D, 4'b1100, 1'b1, 0, 0, 1'b1, 0, 32'h0, "wr_error");
    do_txn(30'h77, 32'h0, 4'b0011, 1'b0, 0, 5, 1'b0, 0, 32'h5A5A1234, "retry5");
    do_txn(30'h78, 32'h0, 4'b1111, 1'b0, 1, 2, 1'b0, 1, 32'h0BADCAFE, "retry2");
    do_txn(30'h79, 32'h11223344, 4'b0101, 1'b1, 0, 0, 1'b0, 0, 32'h0, "illegal");
    do_txn(30'h7A, 32'h0, 4'b0000, 1'b0, 0, 0, 1'b0, 0, 32'h0, "sel_zero");
    do_txn(30'h3FFFFFFF, 32'h0, 4'b1000, 1'b0, 0, 0, 1'b0, 2, 32'h9900AA00, "rd_top");

    // Grant withheld, then the master abandons the cycle
    cfg_gdelay = 1000; issues = 0;
    adr_i = 30'h123; dat_i = 32'h0; sel_i = 4'b1111; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    repeat (4) @(negedge hclk);
    check("abort_busreq_high", hbusreq, 1'b1);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge hclk);
    check("abort_busreq_low", hbusreq, 1'b0);
    repeat (4) @(negedge hclk);
    check("abort_issues", issues, 0);
    cfg_gdelay = 0;

    // Reset asserted during a stretched data phase
    cfg_waits = 5; rt_left = 0; cfg_err = 1'b0; cfg_gdelay = 0; issues = 0;
    exp_addr = {30'h155, 2'b00}; exp_size = 3'b010; exp_write = 1'b1; exp_wdata = 32'hA5A5F00F;
    adr_i = 30'h155; dat_i = 32'hA5A5F00F; sel_i = 4'b1111; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    cyc_cnt = 0;
    do begin
      @(negedge hclk);
      cyc_cnt++;
    end while ((htrans != HTRANS_NONSEQ) && (cyc_cnt < 50));
    check("rst_reached_addr", htrans, HTRANS_NONSEQ);
    @(negedge hclk);
    hresetn = 1'b0;
    @(negedge hclk);
    check_reset_vals("rst_in_data");
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cfg_waits = 0;
    hresetn = 1'b1;
    @(negedge hclk);

    // Randomized traffic against the reference rules
    for (int k = 0; k < 40; k++) begin
      logic [3:0] rsel;
      int         rret;
      rsel = 4'($urandom_range(0, 15));
      rret = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      do_txn(30'($urandom), $urandom, rsel, 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), rret, ($urandom_range(0, 7) == 0),
             $urandom_range(0, 2), $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
